// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory-arbiter state/grant encodings plus the
// existing instruction opcodes and general-register indices.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IBURST = 2'd1,
        DBURST = 2'd2,
        DWRITE = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    localparam logic [4:0] NOP   = 5'b00000;
    localparam logic [4:0] HALT  = 5'b00001;
    localparam logic [4:0] LOAD  = 5'b00010;
    localparam logic [4:0] STORE = 5'b00011;
    localparam logic [4:0] SLL   = 5'b00100;
    localparam logic [4:0] SLA   = 5'b00101;
    localparam logic [4:0] SRL   = 5'b00110;
    localparam logic [4:0] SRA   = 5'b00111;
    localparam logic [4:0] ADD   = 5'b01000;
    localparam logic [4:0] ADDI  = 5'b01001;
    localparam logic [4:0] SUB   = 5'b01010;
    localparam logic [4:0] SUBI  = 5'b01011;
    localparam logic [4:0] CMP   = 5'b01100;
    localparam logic [4:0] AND   = 5'b01101;
    localparam logic [4:0] OR    = 5'b01110;
    localparam logic [4:0] XOR   = 5'b01111;
    localparam logic [4:0] LDIH  = 5'b10000;
    localparam logic [4:0] ADDC  = 5'b10001;
    localparam logic [4:0] SUBC  = 5'b10010;
    localparam logic [4:0] JUMP  = 5'b11000;
    localparam logic [4:0] JMPR  = 5'b11001;
    localparam logic [4:0] BZ    = 5'b11010;
    localparam logic [4:0] BNZ   = 5'b11011;
    localparam logic [4:0] BN    = 5'b11100;
    localparam logic [4:0] BNN   = 5'b11101;
    localparam logic [4:0] BC    = 5'b11110;
    localparam logic [4:0] BNC   = 5'b11111;

    localparam logic [2:0] gr0 = 3'd0;
    localparam logic [2:0] gr1 = 3'd1;
    localparam logic [2:0] gr2 = 3'd2;
    localparam logic [2:0] gr3 = 3'd3;
    localparam logic [2:0] gr4 = 3'd4;
    localparam logic [2:0] gr5 = 3'd5;
    localparam logic [2:0] gr6 = 3'd6;
    localparam logic [2:0] gr7 = 3'd7;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of one memory port between icache line refills and dcache refills/stores.
// Grant one cycle after request seen in IDLE; mem_ready low stalls the current beat indefinitely.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int AW         = 8,
    parameter int DW         = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    output logic          i_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          busy
);

    localparam int              LB        = $clog2(LINE_WORDS);
    localparam logic [AW-1:0]   LINE_MASK = AW'(LINE_WORDS - 1);
    localparam logic [LB-1:0]   BEAT_LAST = LB'(LINE_WORDS - 1);

    arb_state_t    state;
    arb_state_t    state_nxt;
    grant_t        last_grant;
    logic [LB-1:0] beat;
    logic [AW-1:0] base;
    logic [DW-1:0] wdata_q;
    logic          pick_d;
    logic          pick_i;
    logic          last_beat;

    // On a tie the side that did not win last time gets the port.
    assign pick_d    = d_req && (!i_req || last_grant == GNT_I);
    assign pick_i    = i_req && !pick_d;
    assign last_beat = (beat == BEAT_LAST);

    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;
    assign busy    = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick_d) begin
                    state_nxt = d_we ? DWRITE : DBURST;
                end else if (pick_i) begin
                    state_nxt = IBURST;
                end
            end
            IBURST, DBURST: begin
                if (mem_ready && last_beat) begin
                    state_nxt = IDLE;
                end
            end
            DWRITE: begin
                if (mem_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request and address inputs are only looked at while idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant <= GNT_I;
            beat       <= '0;
            base       <= '0;
            wdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        last_grant <= GNT_D;
                        base       <= d_we ? d_addr : (d_addr & ~LINE_MASK);
                        wdata_q    <= d_wdata;
                        beat       <= '0;
                    end else if (pick_i) begin
                        last_grant <= GNT_I;
                        base       <= i_addr & ~LINE_MASK;
                        beat       <= '0;
                    end
                end
                IBURST, DBURST: begin
                    if (mem_ready) begin
                        beat <= beat + LB'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Base is line-aligned during bursts, so OR-ing the beat never carries out of the line.
    always_comb begin
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_rvalid  = 1'b0;
        i_done    = 1'b0;
        d_rvalid  = 1'b0;
        d_done    = 1'b0;
        case (state)
            IBURST: begin
                mem_cs   = 1'b1;
                mem_addr = base | AW'(beat);
                i_rvalid = mem_ready;
                i_done   = mem_ready && last_beat;
            end
            DBURST: begin
                mem_cs   = 1'b1;
                mem_addr = base | AW'(beat);
                d_rvalid = mem_ready;
                d_done   = mem_ready && last_beat;
            end
            DWRITE: begin
                mem_cs    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = base;
                mem_wdata = wdata_q;
                d_done    = mem_ready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed timing scenarios plus randomized traffic checked
// against a transaction-level model of grants, beats and memory contents.
module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int LW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          i_done;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];
    logic          fill;
    logic [15:0]   seed;

    typedef struct packed {
        logic [7:0]  addr;
        logic        we;
        logic [15:0] data;
        logic        is_d;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    bit    last_was_d;

    mem_arbiter #(.AW(AW), .DW(DW), .LINE_WORDS(LW)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] pattern(int i);
        return seed ^ (16'(i) * 16'h9E37);
    endfunction

    assign mem_rdata = mem[mem_addr];

    always @(posedge clock) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) mem[i] <= pattern(i);
        end else if (mem_cs && mem_we && mem_ready) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    wire [6:0] ctl = {busy, mem_cs, mem_we, i_rvalid, i_done, d_rvalid, d_done};

    task automatic next_cycle();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        i_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1;
        idle_inputs();
        @(negedge clock);
        reset = 0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (ctl !== 7'b0) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, 7'b0); end
        checks++;
        if ({mem_addr, mem_wdata} !== 24'h0) begin
            errors++; $display("FAIL reset_bus: got %h/%h expected 00/0000", mem_addr, mem_wdata);
        end
        checks++;
        if ({i_rdata, d_rdata} !== {ref_mem[0], ref_mem[0]}) begin
            errors++; $display("FAIL reset_rdata: got %h/%h expected %h", i_rdata, d_rdata, ref_mem[0]);
        end
        next_cycle();
        reset = 0;
    endtask

    task automatic test_i_refill();
        logic [6:0] exp_ctl;
        logic [7:0] a;
        next_cycle();
        i_req = 1; i_addr = 8'h13; mem_ready = 1;
        #1;
        checks++;
        if (ctl !== 7'b0) begin errors++; $display("FAIL refill_c0: got %b expected %b", ctl, 7'b0); end
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            #1;
            a = 8'h10 + 8'(k);
            exp_ctl = {1'b1, 1'b1, 1'b0, 1'b1, (k == 3), 1'b0, 1'b0};
            checks++;
            if (ctl !== exp_ctl) begin errors++; $display("FAIL refill_ctl c%0d: got %b expected %b", k + 1, ctl, exp_ctl); end
            checks++;
            if ({mem_addr, i_rdata} !== {a, ref_mem[a]}) begin
                errors++; $display("FAIL refill_word c%0d: got %h/%h expected %h/%h", k + 1, mem_addr, i_rdata, a, ref_mem[a]);
            end
        end
        next_cycle();
        i_req = 0;
        #1;
        checks++;
        if (ctl !== 7'b0) begin errors++; $display("FAIL refill_c5: got %b expected %b", ctl, 7'b0); end
    endtask

    task automatic test_contention();
        logic [6:0] exp_ctl;
        logic [7:0] a;
        bit         is_d;
        int         t, p;
        do_reset();
        next_cycle();
        i_req = 1; i_addr = 8'h20; d_req = 1; d_we = 0; d_addr = 8'h40; mem_ready = 1;
        #1;
        for (int c = 1; c <= 20; c++) begin
            next_cycle();
            if (c == 20) begin i_req = 0; d_req = 0; end
            #1;
            t = (c - 1) / 5;
            p = (c - 1) % 5;
            is_d = (t % 2 == 0);
            if (p == 4) exp_ctl = 7'b0;
            else exp_ctl = {1'b1, 1'b1, 1'b0, !is_d, !is_d && p == 3, is_d, is_d && p == 3};
            checks++;
            if (ctl !== exp_ctl) begin errors++; $display("FAIL contend_ctl c%0d: got %b expected %b", c, ctl, exp_ctl); end
            if (p != 4) begin
                a = (is_d ? 8'h40 : 8'h20) + 8'(p);
                checks++;
                if (mem_addr !== a) begin errors++; $display("FAIL contend_addr c%0d: got %h expected %h", c, mem_addr, a); end
            end
        end
    endtask

    task automatic test_store_wait();
        logic [6:0] exp_ctl;
        next_cycle();
        d_req = 1; d_we = 1; d_addr = 8'h7F; d_wdata = 16'hBEEF; mem_ready = 0;
        #1;
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            if (c == 1) begin d_addr = 8'h00; d_wdata = 16'h1234; end
            mem_ready = (c == 4);
            #1;
            exp_ctl = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, (c == 4)};
            checks++;
            if (ctl !== exp_ctl) begin errors++; $display("FAIL store_ctl c%0d: got %b expected %b", c, ctl, exp_ctl); end
            checks++;
            if ({mem_addr, mem_wdata} !== {8'h7F, 16'hBEEF}) begin
                errors++; $display("FAIL store_bus c%0d: got %h/%h expected 7f/beef", c, mem_addr, mem_wdata);
            end
        end
        ref_mem[8'h7F] = 16'hBEEF;
        next_cycle();
        d_req = 0; mem_ready = 0;
        #1;
        checks++;
        if (ctl !== 7'b0) begin errors++; $display("FAIL store_end: got %b expected %b", ctl, 7'b0); end
    endtask

    task automatic test_stall_burst();
        logic [7:0] line, a;
        int  got = 0;
        bit  done_seen = 0;
        line = 8'($urandom) & 8'hFC;
        next_cycle();
        i_req = 1; i_addr = line | 8'($urandom_range(0, 3)); mem_ready = 0;
        #1;
        for (int c = 1; c <= 20 && !done_seen; c++) begin
            next_cycle();
            mem_ready = (c % 2 == 1);
            #1;
            a = line + 8'(got);
            checks++;
            if ({mem_cs, mem_addr, i_rvalid} !== {1'b1, a, mem_ready}) begin
                errors++; $display("FAIL stall_beat c%0d: got cs%b %h v%b expected cs1 %h v%b", c, mem_cs, mem_addr, i_rvalid, a, mem_ready);
            end
            if (i_rvalid) begin
                checks++;
                if ({i_rdata, i_done} !== {ref_mem[a], (got == 3)}) begin
                    errors++; $display("FAIL stall_word %0d: got %h/%b expected %h/%b", got, i_rdata, i_done, ref_mem[a], got == 3);
                end
                got++;
            end
            if (i_done) done_seen = 1;
        end
        checks++;
        if (got !== 4 || !done_seen) begin errors++; $display("FAIL stall_count: got %0d words done=%b expected 4 done=1", got, done_seen); end
        next_cycle();
        i_req = 0;
        #1;
    endtask

    task automatic test_reset_mid();
        logic [7:0] line;
        logic [6:0] exp_ctl;
        line = 8'($urandom) & 8'hFC;
        next_cycle();
        d_req = 1; d_we = 0; d_addr = line | 8'h2; mem_ready = 1;
        #1;
        repeat (2) next_cycle();
        next_cycle();
        #1;
        checks++;
        if ({d_rvalid, mem_addr} !== {1'b1, line + 8'h2}) begin
            errors++; $display("FAIL rstmid_beat2: got v%b %h expected v1 %h", d_rvalid, mem_addr, line + 8'h2);
        end
        reset = 1;
        #1;
        checks++;
        if ({ctl, mem_addr} !== 15'b0) begin errors++; $display("FAIL rstmid_async: got %b/%h expected 0/00", ctl, mem_addr); end
        next_cycle();
        reset = 0;
        #1;
        checks++;
        if (ctl !== 7'b0) begin errors++; $display("FAIL rstmid_idle: got %b expected %b", ctl, 7'b0); end
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            #1;
            exp_ctl = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, (k == 3)};
            checks++;
            if ({ctl, mem_addr} !== {exp_ctl, line + 8'(k)}) begin
                errors++; $display("FAIL rstmid_retry k%0d: got %b/%h expected %b/%h", k, ctl, mem_addr, exp_ctl, line + 8'(k));
            end
        end
        next_cycle();
        d_req = 0;
        #1;
    endtask

    task automatic test_drop();
        logic [7:0] li, ld, a;
        logic [6:0] exp_ctl;
        li = 8'($urandom) & 8'hFC;
        ld = 8'($urandom) & 8'hFC;
        next_cycle();
        i_req = 1; i_addr = li; d_req = 0; mem_ready = 1;
        #1;
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            if (c == 3) begin i_req = 0; d_req = 1; d_we = 0; d_addr = ld | 8'h1; end
            if (c == 10) d_req = 0;
            #1;
            if (c == 5 || c == 10) begin
                exp_ctl = 7'b0;
                a = 8'h00;
            end else if (c < 5) begin
                exp_ctl = {1'b1, 1'b1, 1'b0, 1'b1, (c == 4), 1'b0, 1'b0};
                a = li + 8'(c - 1);
            end else begin
                exp_ctl = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, (c == 9)};
                a = ld + 8'(c - 6);
            end
            checks++;
            if ({ctl, mem_addr} !== {exp_ctl, a}) begin
                errors++; $display("FAIL drop c%0d: got %b/%h expected %b/%h", c, ctl, mem_addr, exp_ctl, a);
            end
        end
    endtask

    task automatic push_txn(input bit is_d, input bit we, input logic [7:0] a, input logic [15:0] wd);
        beat_t b;
        logic [7:0] base;
        if (we) begin
            b.addr = a; b.we = 1; b.data = wd; b.is_d = 1; b.last = 1;
            exp_q.push_back(b);
            ref_mem[a] = wd;
        end else begin
            base = a & 8'hFC;
            for (int k = 0; k < LW; k++) begin
                b.addr = base + 8'(k); b.we = 0; b.data = ref_mem[base + 8'(k)];
                b.is_d = is_d; b.last = (k == LW - 1);
                exp_q.push_back(b);
            end
        end
        last_was_d = is_d;
    endtask

    task automatic test_random();
        beat_t       e;
        logic [3:0]  exp_strb;
        logic [15:0] obs_data;
        int          scen, cyc;
        bit          drop_i, drop_d, ok;
        logic [7:0]  ia, da;
        logic [15:0] wd;
        bit          dwe;
        do_reset();
        last_was_d = 0;
        for (int it = 0; it < 25; it++) begin
            scen = $urandom_range(0, 2);
            ia = 8'($urandom); da = 8'($urandom); wd = 16'($urandom); dwe = 1'($urandom);
            if (scen == 0) push_txn(0, 0, ia, 16'h0);
            else if (scen == 1) push_txn(1, dwe, da, wd);
            else if (last_was_d) begin push_txn(0, 0, ia, 16'h0); push_txn(1, dwe, da, wd); end
            else begin push_txn(1, dwe, da, wd); push_txn(0, 0, ia, 16'h0); end
            next_cycle();
            i_req = (scen != 1); i_addr = ia;
            d_req = (scen != 0); d_addr = da; d_we = dwe; d_wdata = wd;
            mem_ready = 1'($urandom);
            #1;
            drop_i = 0; drop_d = 0; ok = 0;
            for (cyc = 0; cyc < 200; cyc++) begin
                next_cycle();
                if (drop_i) i_req = 0;
                if (drop_d) d_req = 0;
                mem_ready = ($urandom_range(0, 3) != 0);
                #1;
                if (mem_cs && mem_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++; $display("FAIL rand_extra it%0d: got beat at %h expected none", it, mem_addr);
                    end else begin
                        e = exp_q.pop_front();
                        exp_strb = {!e.is_d, !e.is_d && e.last, e.is_d && !e.we, e.is_d && e.last};
                        obs_data = e.we ? mem_wdata : (e.is_d ? d_rdata : i_rdata);
                        if ({mem_addr, mem_we, obs_data, i_rvalid, i_done, d_rvalid, d_done} !== {e.addr, e.we, e.data, exp_strb}) begin
                            errors++;
                            $display("FAIL rand_beat it%0d: got %h w%b %h %b expected %h w%b %h %b", it, mem_addr, mem_we, obs_data,
                                     {i_rvalid, i_done, d_rvalid, d_done}, e.addr, e.we, e.data, exp_strb);
                        end
                    end
                end else begin
                    checks++;
                    if ({i_rvalid, i_done, d_rvalid, d_done} !== 4'b0) begin
                        errors++; $display("FAIL rand_strobe it%0d: got %b expected 0000", it, {i_rvalid, i_done, d_rvalid, d_done});
                    end
                end
                if (i_done) drop_i = 1;
                if (d_done) drop_d = 1;
                if (exp_q.size() == 0 && !i_req && !d_req && !busy) begin ok = 1; break; end
            end
            checks++;
            if (!ok) begin
                errors++; $display("FAIL rand_timeout it%0d: got %0d beats left expected 0", it, exp_q.size());
                exp_q.delete();
                do_reset();
                last_was_d = 0;
            end
        end
    endtask

    initial begin
        seed = 16'($urandom);
        fill = 1;
        reset = 1;
        idle_inputs();
        for (int i = 0; i < 256; i++) ref_mem[i] = pattern(i);
        repeat (2) @(negedge clock);
        fill = 0;
        test_reset();
        test_i_refill();
        test_contention();
        test_store_wait();
        test_stall_burst();
        test_reset_mid();
        test_drop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1);
    end

endmodule
